wrf_frame_gen: RTL
==================

# wrf_frame_gen

Programmable WR-fabric frame transmitter: a pipelined 16-bit Wishbone fabric master that emits Ethernet frames with a fixed header and LFSR payload at a controlled rate. It is the transmit counterpart of the fabric sinks used around the FEC encoder/decoder and the packet dropper. It drives fabric traffic into the encoder or loopback path without a testbench packet source, so the same stimulus can run on hardware. A 32-bit Wishbone slave configures it and reads back its counters.

## Interface
- g_dst_mac, 48'hFFFF_FFFF_FFFF, destination MAC in the header
- g_src_mac, 48'h0102_0304_0506, source MAC in the header
- clk_i  in  1  system clock; all logic rising-edge
- rst_n  in  1  reset, asynchronous, active-high
- src_cyc_o  out  1  fabric cycle; high for a whole frame
- src_stb_o  out  1  fabric strobe; one word per strobe
- src_we_o  out  1  constant 1
- src_adr_o  out  2  2'b01 for the status word, 2'b00 for data
- src_sel_o  out  2  byte lanes; 2'b10 only on an odd final payload byte
- src_dat_o  out  16  fabric data
- src_stall_i  in  1  sink stall
- src_ack_i  in  1  sink acknowledge
- src_err_i  in  1  sink error; aborts the frame
- wb_cyc_i, wb_stb_i, wb_we_i  in  1  control slave strobes
- wb_adr_i  in  3  word address
- wb_dat_i  in  32  write data
- wb_dat_o  out  32  read data
- wb_ack_o  out  1  acknowledge, 1 cycle after cyc&stb
- wb_stall_o  out  1  tied 0

## Operation

Registers (word addresses):
- 0 CTRL: bit0 EN (continuous mode); bit1 ONESHOT (write 1 sends one frame; self-clears when that frame starts).
- 1 LEN[10:0]: payload bytes. Values <46 are used as 46; values >1500 are used as 1500. Clamping is applied when the frame starts.
- 2 GAP[15:0]: idle cycles between frames.
- 3 SEED[15:0]: LFSR seed. A value of 0 is replaced by 16'hACE1.
- 4 ETYPE[15:0]: ethertype field.
- 5 TX_CNT: read-only count of completed frames.
- 6 ERR_CNT: read-only count of aborted frames.
- Writing 1 to bit31 of address 5 or 6 clears that counter.
- Register reset values: CTRL=0, LEN=64, GAP=16, SEED=16'hACE1, ETYPE=16'h0800.

Frame structure, in order:
- 1 status word: adr=01, dat=0.
- 7 header words: dst[47:32], dst[31:16], dst[15:0], src ×3 in the same order, ETYPE.
- ceil(L/2) payload words from the LFSR (adr=00). If L is odd, the last word carries sel=10 and byte [15:8] valid.

LFSR:
- Polynomial x^16+x^14+x^13+x^11+1, Fibonacci form.
- Loaded from SEED at frame start; current value is output, then the LFSR advances on each accepted payload word.

FSM states: IDLE, STATUS, HDR, PAYLOAD, DRAIN, GAP.
- IDLE: moves to STATUS when EN=1 or ONESHOT=1. In the same cycle it latches L and SEED and asserts cyc.
- STATUS → HDR → PAYLOAD: a word is accepted when stb & !stall. The word counter advances only on acceptance; stb and data stay stable while stalled.
- PAYLOAD → DRAIN: after the last word is accepted; stb drops.
- DRAIN: waits until outstanding=0 (outstanding = accepted words − acks), then drops cyc, increments TX_CNT, enters GAP.
- GAP: counts GAP cycles, then returns to IDLE. With GAP=0 it returns to IDLE after 1 cycle.
- src_err_i in any state with cyc=1: drop cyc and stb the next cycle, increment ERR_CNT, enter GAP.

Other rules:
- EN cleared mid-frame: the current frame completes; no further frame starts.
- Register writes to LEN, SEED or ETYPE mid-frame take effect on the next frame.
- Ack and accept in the same cycle leave outstanding unchanged. Outstanding is 12 bits and never wraps (at most 758 words per frame).
- Counters are 32 bits and wrap from 0xFFFFFFFF to 0.

## Timing
- Reset values: all src_* outputs 0 except src_we_o=1; wb_ack_o=0; wb_dat_o=0; FSM in IDLE.
- cyc and stb rise 1 cycle after the start condition is registered.
- With no stall, one word per cycle: a frame occupies 8+ceil(L/2) consecutive strobe cycles.
- cyc falls the cycle after the final ack.
- Back-to-back frames: cyc stays low for at least GAP+1 cycles.
- Reset asserted mid-frame drops cyc and stb immediately (asynchronous). No counter increments.

## Test plan
- LEN=64, GAP=16, EN=1, sink never stalls → 40 words per frame: status, header FFFF×3, 0102/0304/0506, 0800, then the LFSR sequence from ACE1. TX_CNT increments once per frame. Inter-frame cyc low time is 17 cycles.
- LEN=47 via ONESHOT → 32 words; the last word has sel=10. Exactly one frame is sent, TX_CNT=1, CTRL reads 0.
- LEN=10 and LEN=2000 → frames carry 46 and 1500 payload bytes (31 and 758 words).
- Random stall and delayed ack (up to 5 cycles) → identical word sequence with stable data while stalled. cyc falls only after the last ack.
- src_err_i pulsed at header word 3 → cyc=0 the next cycle, ERR_CNT=1, TX_CNT unchanged. The next frame restarts from the status word with the LFSR reloaded.
- SEED=0 → payload begins with ACE1. Write bit31 to address 5 → TX_CNT reads 0.

Source files
------------

// File: rtl/wrf_frame_gen.sv
// wrf_frame_gen: WR-fabric frame transmitter (fixed header + LFSR payload) with a Wishbone control slave
// Ports: clk_i, rst_n (async, active-high); src_* pipelined 16-bit fabric master;
//        wb_* 32-bit control slave: 0 CTRL, 1 LEN, 2 GAP, 3 SEED, 4 ETYPE, 5 TX_CNT, 6 ERR_CNT
module wrf_frame_gen #(
    parameter logic [47:0] g_dst_mac = 48'hFFFF_FFFF_FFFF,
    parameter logic [47:0] g_src_mac = 48'h0102_0304_0506
) (
    input  logic        clk_i,
    input  logic        rst_n,
    output logic        src_cyc_o,
    output logic        src_stb_o,
    output logic        src_we_o,
    output logic [1:0]  src_adr_o,
    output logic [1:0]  src_sel_o,
    output logic [15:0] src_dat_o,
    input  logic        src_stall_i,
    input  logic        src_ack_i,
    input  logic        src_err_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [2:0]  wb_adr_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        wb_stall_o
);
    typedef enum logic [2:0] {S_IDLE, S_STATUS, S_HDR, S_PAYLOAD, S_DRAIN, S_GAP} state_t;
    state_t state, state_nx;
    logic en, oneshot, odd, wr, acc, ackd, abort, start, last_hdr, last_pl, gap_done, done;
    logic [10:0] len, len_c;
    logic [15:0] gap, seed, etype, etype_l, lfsr, gcnt, hdr_w;
    logic [9:0] nwords, widx;
    logic [11:0] outst, out_nx;
    logic [31:0] tx_cnt, err_cnt;
    assign wr = wb_cyc_i & wb_stb_i & wb_we_i;
    assign src_cyc_o = state inside {S_STATUS, S_HDR, S_PAYLOAD, S_DRAIN};
    assign src_stb_o = state inside {S_STATUS, S_HDR, S_PAYLOAD};
    assign src_we_o = 1'b1;
    assign src_adr_o = (state == S_STATUS) ? 2'b01 : 2'b00;
    assign acc = src_stb_o & ~src_stall_i;
    // an ack with nothing outstanding is ignored so the counter cannot underflow
    assign ackd = src_cyc_o & src_ack_i & (outst != 12'd0);
    assign out_nx = outst + {11'd0, acc} - {11'd0, ackd};
    assign abort = src_cyc_o & src_err_i;
    assign start = (state == S_IDLE) & (en | oneshot);
    assign len_c = (len < 11'd46) ? 11'd46 : (len > 11'd1500) ? 11'd1500 : len;
    assign last_hdr = (widx == 10'd6);
    assign last_pl = (widx == nwords - 10'd1);
    assign gap_done = ({1'b0, gcnt} + 17'd1) >= {1'b0, gap};
    // decided on the next-cycle outstanding count so cyc falls right after the final ack
    assign done = (state == S_DRAIN) & (out_nx == 12'd0) & ~abort;
    assign wb_stall_o = 1'b0;
    assign hdr_w = (widx[2:0] == 3'd0) ? g_dst_mac[47:32] :
                   (widx[2:0] == 3'd1) ? g_dst_mac[31:16] :
                   (widx[2:0] == 3'd2) ? g_dst_mac[15:0]  :
                   (widx[2:0] == 3'd3) ? g_src_mac[47:32] :
                   (widx[2:0] == 3'd4) ? g_src_mac[31:16] :
                   (widx[2:0] == 3'd5) ? g_src_mac[15:0]  : etype_l;
    assign src_dat_o = (state == S_HDR) ? hdr_w : (state == S_PAYLOAD) ? lfsr : 16'h0000;
    assign src_sel_o = ~src_stb_o ? 2'b00 : ((state == S_PAYLOAD) & last_pl & odd) ? 2'b10 : 2'b11;
    always_comb begin
        state_nx = state;
        if (abort)
            state_nx = S_GAP;
        else
            case (state)
                S_IDLE:    state_nx = start ? S_STATUS : S_IDLE;
                S_STATUS:  state_nx = acc ? S_HDR : S_STATUS;
                S_HDR:     state_nx = (acc & last_hdr) ? S_PAYLOAD : S_HDR;
                S_PAYLOAD: state_nx = (acc & last_pl) ? S_DRAIN : S_PAYLOAD;
                S_DRAIN:   state_nx = done ? S_GAP : S_DRAIN;
                S_GAP:     state_nx = gap_done ? S_IDLE : S_GAP;
                default:   state_nx = S_IDLE;
            endcase
    end
    always_ff @(posedge clk_i or posedge rst_n)
        if (rst_n) state <= S_IDLE;
        else state <= state_nx;
    always_ff @(posedge clk_i or posedge rst_n) begin
        if (rst_n) begin
            en <= 1'b0;
            oneshot <= 1'b0;
            len <= 11'd64;
            gap <= 16'd16;
            seed <= 16'hACE1;
            etype <= 16'h0800;
            etype_l <= 16'h0800;
            lfsr <= 16'hACE1;
            nwords <= 10'd0;
            odd <= 1'b0;
            widx <= 10'd0;
            outst <= 12'd0;
            gcnt <= 16'd0;
            tx_cnt <= 32'd0;
            err_cnt <= 32'd0;
            wb_ack_o <= 1'b0;
            wb_dat_o <= 32'd0;
        end else begin
            wb_ack_o <= wb_cyc_i & wb_stb_i;
            if (wb_cyc_i & wb_stb_i)
                wb_dat_o <= (wb_adr_i == 3'd0) ? {30'd0, oneshot, en} :
                            (wb_adr_i == 3'd1) ? {21'd0, len} :
                            (wb_adr_i == 3'd2) ? {16'd0, gap} :
                            (wb_adr_i == 3'd3) ? {16'd0, seed} :
                            (wb_adr_i == 3'd4) ? {16'd0, etype} :
                            (wb_adr_i == 3'd5) ? tx_cnt :
                            (wb_adr_i == 3'd6) ? err_cnt : 32'd0;
            if (wr & (wb_adr_i == 3'd0)) begin
                en <= wb_dat_i[0];
                oneshot <= wb_dat_i[1];
            end else if (start)
                oneshot <= 1'b0;
            if (wr & (wb_adr_i == 3'd1)) len <= wb_dat_i[10:0];
            if (wr & (wb_adr_i == 3'd2)) gap <= wb_dat_i[15:0];
            if (wr & (wb_adr_i == 3'd3)) seed <= wb_dat_i[15:0];
            if (wr & (wb_adr_i == 3'd4)) etype <= wb_dat_i[15:0];
            if (wr & (wb_adr_i == 3'd5) & wb_dat_i[31]) tx_cnt <= 32'd0;
            else if (done) tx_cnt <= tx_cnt + 32'd1;
            if (wr & (wb_adr_i == 3'd6) & wb_dat_i[31]) err_cnt <= 32'd0;
            else if (abort) err_cnt <= err_cnt + 32'd1;
            // frame parameters are snapshotted so mid-frame register writes apply to the next frame
            if (start) begin
                nwords <= 10'((len_c + 11'd1) >> 1);
                odd <= len_c[0];
                lfsr <= (seed == 16'd0) ? 16'hACE1 : seed;
                etype_l <= etype;
                widx <= 10'd0;
            end else begin
                if (acc) widx <= ((state == S_STATUS) | ((state == S_HDR) & last_hdr)) ? 10'd0 : widx + 10'd1;
                if (acc & (state == S_PAYLOAD)) lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
            end
            outst <= (src_cyc_o & ~abort) ? out_nx : 12'd0;
            gcnt <= (state == S_GAP) ? gcnt + 16'd1 : 16'd0;
        end
    end
endmodule
